// File: rtl/div_arb_pkg.sv
// Shared types, IEEE-754 double constants and special-operand classifiers
// for the divider arbiter.
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [63:0] QNAN_D    = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INF_D     = 64'h7FF0_0000_0000_0000;
    localparam logic [10:0] EXP_MAX_D = 11'h7FF;

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == EXP_MAX_D) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic is_inf(input logic [63:0] x);
        return (x[62:52] == EXP_MAX_D) && (x[51:0] == 52'd0);
    endfunction

    function automatic logic is_zero(input logic [63:0] x);
        return x[62:0] == 63'd0;
    endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr,
// wrapping explicitly so N_REQ need not be a power of two.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && (j == idx) && valid[j]) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one fixed-latency double divider among N_REQ requesters.
// Optional DIV_ARB_FASTPATH_EN resolves special operands without the divider.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DIV_LAT = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [64*N_REQ-1:0] req_a,
    input  logic [64*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    resp_valid,
    input  logic [N_REQ-1:0]    resp_ready,
    output logic [63:0]         resp_z,
    output logic                busy,
    output logic                div_start,
    output logic [63:0]         div_a,
    output logic [63:0]         div_b,
    input  logic [63:0]         div_z
);

    // state | meaning
    // IDLE  | arbitrate, accept one request, latch operands and owner
    // ISSUE | div_start pulse, load latency counter
    // WAIT  | count down, capture div_z when cnt reaches 1
    // RESP  | hold resp_valid[owner] and resp_z until owner accepts

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(DIV_LAT + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     owner;
    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     sel_idx;
    logic [63:0]       sel_a;
    logic [63:0]       sel_b;
    logic              accept;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Gated by reset so every output reads 0 while reset is held.
    assign req_ready = (state == IDLE && reset) ? grant : '0;
    assign accept    = (state == IDLE) && (|grant);

    always_comb begin
        sel_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant[j]) begin
                sel_idx = PW'(j);
                sel_a   = req_a[64*j +: 64];
                sel_b   = req_b[64*j +: 64];
            end
        end
    end

`ifdef DIV_ARB_FASTPATH_EN
    logic        fast_hit;
    logic [63:0] fast_z;
    logic        sgn;

    always_comb begin
        sgn      = sel_a[63] ^ sel_b[63];
        fast_hit = 1'b1;
        fast_z   = QNAN_D;
        if (is_nan(sel_a) || is_nan(sel_b) ||
            (is_zero(sel_a) && is_zero(sel_b)) ||
            (is_inf(sel_a) && is_inf(sel_b)))
            fast_z = QNAN_D;
        else if (is_zero(sel_b) || is_inf(sel_a))
            fast_z = INF_D | {sgn, 63'd0};
        else if (is_zero(sel_a) || is_inf(sel_b))
            fast_z = {sgn, 63'd0};
        else
            fast_hit = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            owner      <= '0;
            resp_valid <= '0;
            resp_z     <= '0;
            busy       <= 1'b0;
            div_start  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_a <= sel_a;
                        div_b <= sel_b;
                        owner <= sel_idx;
                        busy  <= 1'b1;
`ifdef DIV_ARB_FASTPATH_EN
                        if (fast_hit) begin
                            resp_z     <= fast_z;
                            resp_valid <= grant;
                            state      <= RESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
`else
                        div_start <= 1'b1;
                        state     <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(DIV_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        resp_z     <= div_z;
                        resp_valid <= N_REQ'(1) << owner;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        ptr        <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: cycle-level transaction model plus
// directed scenarios with literal expectations; works with or without DIV_ARB_FASTPATH_EN.
module tb_div_arbiter;

    localparam int N   = 4;
    localparam int LAT = 30;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [64*N-1:0]  req_a, req_b;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready = '0;
    logic [63:0]      resp_z, div_a, div_b, div_z;
    logic             busy, div_start;

    logic [63:0]      op_a [N];
    logic [63:0]      op_b [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_a[64*gi +: 64] = op_a[gi];
        assign req_b[64*gi +: 64] = op_b[gi];
    end

    div_arbiter #(.N_REQ(N), .DIV_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .busy       (busy),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_z      (div_z)
    );

    // Divider model: garbage until LAT cycles after the start cycle.
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) / $bitstoreal(b));
    endfunction

    int since = 1000;
    always @(posedge clk) begin
        if (div_start) since <= 1;
        else if (since < 1000) since <= since + 1;
    end
    assign div_z = (since >= LAT) ? ref_div(div_a, div_b) : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) if (j == i) v[j] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] model_result(input logic [63:0] a, input logic [63:0] b,
                                                 output bit fast);
        bit an, bn, ai, bi, az, bz;
        logic s;
        an = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
        bn = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
        ai = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
        bi = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
        az = (a[62:0] == 0);
        bz = (b[62:0] == 0);
        s  = a[63] ^ b[63];
        fast = 1'b0;
`ifdef DIV_ARB_FASTPATH_EN
        fast = 1'b1;
        if (an || bn || (az && bz) || (ai && bi)) return 64'h7FF8_0000_0000_0000;
        if ((bz && !az) || (ai && !bi)) return {s, 11'h7FF, 52'd0};
        if (az || bi) return {s, 63'd0};
        fast = 1'b0;
`endif
        return ref_div(a, b);
    endfunction

    // Transaction model: one op in flight, predicted by cycle numbers.
    bit          m_busy = 1'b0;
    int          m_owner = 0, m_ptr = 0, m_start_c = -1, m_resp_c = 0;
    logic [63:0] m_a = '0, m_b = '0, m_z = '0, m_pend = '0;

    always @(negedge clk) begin
        logic [N-1:0] e_ready, e_rv;
        logic         e_start;
        int           g;
        bit           fast;
        e_ready = '0; e_rv = '0; e_start = 1'b0; g = -1; fast = 1'b0;
        if (!reset) begin
            m_busy = 1'b0; m_ptr = 0; m_a = '0; m_b = '0; m_z = '0; m_start_c = -1;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) e_ready = onehot(g);
        end else begin
            e_start = (cyc == m_start_c);
            if (cyc == m_resp_c) m_z = m_pend;
            if (cyc >= m_resp_c) e_rv = onehot(m_owner);
        end
        chk("m_req_ready", req_ready, e_ready);
        chk("m_resp_valid", resp_valid, e_rv);
        chk("m_resp_z", resp_z, m_z);
        chk("m_busy", busy, m_busy);
        chk("m_div_start", div_start, e_start);
        chk("m_div_a", div_a, m_a);
        chk("m_div_b", div_b, m_b);
        if (reset) begin
            if (!m_busy && g >= 0) begin
                m_busy  = 1'b1;
                m_owner = g;
                m_a     = op_a[g];
                m_b     = op_b[g];
                m_pend  = model_result(m_a, m_b, fast);
                if (fast) begin
                    m_start_c = -1;
                    m_resp_c  = cyc + 1;
                end else begin
                    m_start_c = cyc + 1;
                    m_resp_c  = cyc + LAT + 2;
                end
            end else if (m_busy && cyc >= m_resp_c && resp_ready[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
    end

    // Event log of what the DUT actually did.
    int          g_idx_q[$], g_cyc_q[$], st_q[$], rv_cyc_q[$];
    logic [N-1:0] rv_vec_q[$];
    logic [63:0] rv_z_q[$];
    logic [N-1:0] prev_rv = '0;

    always @(negedge clk) begin
        for (int j = 0; j < N; j++)
            if (req_valid[j] && req_ready[j]) begin
                g_idx_q.push_back(j);
                g_cyc_q.push_back(cyc);
            end
        if (div_start) st_q.push_back(cyc);
        if (resp_valid != '0 && prev_rv == '0) begin
            rv_cyc_q.push_back(cyc);
            rv_vec_q.push_back(resp_valid);
            rv_z_q.push_back(resp_z);
        end
        prev_rv = resp_valid;
    end

    task automatic clear_log();
        g_idx_q.delete(); g_cyc_q.delete(); st_q.delete();
        rv_cyc_q.delete(); rv_vec_q.delete(); rv_z_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (g_idx_q.size() < n && k < 400) begin step(); k++; end
        if (g_idx_q.size() < n) tmo("grant_wait");
    endtask

    task automatic wait_rv(input int n);
        int k = 0;
        while (rv_cyc_q.size() < n && k < 400) begin step(); k++; end
        if (rv_cyc_q.size() < n) tmo("resp_wait");
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin step(); k++; end
        if (busy) tmo("idle_wait");
    endtask

    task automatic single_op(input int i, input logic [63:0] a, input logic [63:0] b);
        op_a[i] = a;
        op_b[i] = b;
        clear_log();
        req_valid = onehot(i);
        wait_grants(1);
        req_valid = '0;
        wait_rv(1);
        wait_idle();
    endtask

    initial begin
        op_a[0] = 64'h3FF0_0000_0000_0000;
        op_a[1] = 64'h4000_0000_0000_0000;
        op_a[2] = 64'h4008_0000_0000_0000;
        op_a[3] = 64'h4010_0000_0000_0000;
        for (int i = 0; i < N; i++) op_b[i] = 64'h4000_0000_0000_0000;

        // Reset with all requesters already valid.
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        repeat (3) step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_z", resp_z, 0);
        reset = 1'b1;

        // Continuous requests: strict rotation 0,1,2,3,0.
        wait_grants(5);
        req_valid = '0;
        wait_idle();
        if (g_idx_q.size() >= 5) begin
            chk("rot_0", g_idx_q[0], 0);
            chk("rot_1", g_idx_q[1], 1);
            chk("rot_2", g_idx_q[2], 2);
            chk("rot_3", g_idx_q[3], 3);
            chk("rot_4", g_idx_q[4], 0);
        end
        chk("rot_starts", st_q.size(), 5);

        // Single op on requester 2: 6.0 / 2.0.
        single_op(2, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000);
        if (g_cyc_q.size() > 0 && st_q.size() > 0 && rv_cyc_q.size() > 0) begin
            chk("single_grant", g_idx_q[0], 2);
            chk("single_start_cyc", st_q[0], g_cyc_q[0] + 1);
            chk("single_resp_cyc", rv_cyc_q[0], g_cyc_q[0] + 32);
            chk("single_resp_vec", rv_vec_q[0], 4'b0100);
            chk("single_resp_z", rv_z_q[0], 64'h4008_0000_0000_0000);
        end
        chk("single_starts", st_q.size(), 1);

        // Serve 1, then 0 and 3 contend: 3 must win first.
        single_op(1, 64'h4010_0000_0000_0000, 64'h4000_0000_0000_0000);
        clear_log();
        req_valid = 4'b1001;
        wait_grants(2);
        req_valid = '0;
        wait_idle();
        if (g_idx_q.size() >= 2) begin
            chk("contend_first", g_idx_q[0], 3);
            chk("contend_second", g_idx_q[1], 0);
        end

        // Backpressure in RESP; non-owner resp_ready must be ignored.
        resp_ready = '0;
        op_a[0] = 64'h4024_0000_0000_0000;
        op_b[0] = 64'h4014_0000_0000_0000;
        clear_log();
        req_valid = 4'b0001;
        wait_grants(1);
        req_valid  = 4'b1111;
        resp_ready = 4'b1110;
        wait_rv(1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_req_ready", req_ready, 0);
            chk("hold_div_start", div_start, 0);
            chk("hold_resp_z", resp_z, 64'h4000_0000_0000_0000);
            chk("hold_resp_valid", resp_valid, 4'b0001);
            step();
        end
        resp_ready = 4'b0001;
        step();
        chk("release_idle", busy, 0);
        chk("release_grant", req_ready, 4'b0010);
        step();
        req_valid  = '0;
        resp_ready = 4'b1111;
        wait_idle();

        // 1.0 / 0.0 on requester 3.
        single_op(3, 64'h3FF0_0000_0000_0000, 64'h0);
        if (g_cyc_q.size() > 0 && rv_cyc_q.size() > 0) begin
`ifdef DIV_ARB_FASTPATH_EN
            chk("fast_resp_cyc", rv_cyc_q[0], g_cyc_q[0] + 1);
            chk("fast_starts", st_q.size(), 0);
`else
            chk("slow_resp_cyc", rv_cyc_q[0], g_cyc_q[0] + 32);
            chk("slow_starts", st_q.size(), 1);
`endif
            chk("div0_resp_vec", rv_vec_q[0], 4'b1000);
            chk("div0_resp_z", rv_z_q[0], 64'h7FF0_0000_0000_0000);
        end

        // Reset during WAIT: ptr moved to 2 beforehand, must return to 0.
        single_op(1, 64'h4020_0000_0000_0000, 64'h4000_0000_0000_0000);
        clear_log();
        op_a[2] = 64'h4014_0000_0000_0000;
        op_b[2] = 64'h4000_0000_0000_0000;
        req_valid = 4'b0100;
        wait_grants(1);
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        req_valid = 4'b1111;
        reset = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_resp_z", resp_z, 0);
        chk("arst_busy", busy, 0);
        chk("arst_div_start", div_start, 0);
        chk("arst_div_a", div_a, 0);
        chk("arst_div_b", div_b, 0);
        step();
        step();
        reset = 1'b1;
        req_valid = 4'b1010;
        clear_log();
        wait_grants(1);
        req_valid = '0;
        if (g_idx_q.size() > 0) chk("post_reset_grant", g_idx_q[0], 1);
        wait_rv(1);
        wait_idle();

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle double-precision divider among `N_REQ` requesters. Each requester sees a valid/ready request channel and a valid/ready response channel. The divider exposes only `start`/operands/result and no done flag, so this block pulses start, holds operands stable, counts a fixed latency and captures the quotient. The block sits between the FP issue logic and the divider instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `DIV_LAT`, 30: cycles from the divider's start pulse until its result is stable; must be at least 2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: one-hot grant; the request is accepted when `req_valid[i] & req_ready[i]`.
- `req_a` in 64*N_REQ: dividend, IEEE-754 double, slice i is `[64*i+63:64*i]`.
- `req_b` in 64*N_REQ: divisor, same slicing.
- `resp_valid` out N_REQ: one-hot response valid to the owning requester.
- `resp_ready` in N_REQ: per-requester response accept.
- `resp_z` out 64: quotient, shared by all requesters.
- `busy` out 1: high in every state except IDLE.
- `div_start` out 1: one-cycle start pulse to the divider.
- `div_a` out 64: dividend operand to the divider, held stable.
- `div_b` out 64: divisor operand to the divider, held stable.
- `div_z` in 64: result from the divider.

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, `req_ready[g]` is asserted combinationally for the winner g. On handshake:
    - latch `req_a[g]` into `div_a` and `req_b[g]` into `div_b`;
    - latch g into `owner`;
    - go to ISSUE.
  - ISSUE: `div_start=1` for exactly one cycle; load `cnt=DIV_LAT`; go to WAIT.
  - WAIT: `cnt` decrements each cycle. In the cycle where `cnt==1`, capture `div_z` into `resp_z` and go to RESP.
  - RESP: hold `resp_valid[owner]=1` and `resp_z` stable until `resp_ready[owner]`. On that handshake:
    - set `ptr <= (owner+1) mod N_REQ`;
    - go to IDLE.
- Arbitration: the winner is the first index with `req_valid` high, searching `ptr`, `ptr+1`, … modulo N_REQ. `ptr` resets to 0.
- Only one operation is in flight. `req_ready` is all-zero outside IDLE.
- `resp_ready` bits of non-owners are ignored. `req_valid` deasserting outside IDLE has no effect.
- `div_a`/`div_b` change only on an IDLE accept.
- Reset values:
  - all outputs, `resp_z`, `div_a`, `div_b`, `cnt` and `ptr` are 0;
  - state is IDLE.
- Reset asserted mid-operation: the block returns to IDLE immediately and asynchronously, and the in-flight result is discarded. The divider's own reset is the system's responsibility.
- Width rules:
  - `cnt` is `$clog2(DIV_LAT+1)` bits;
  - `ptr` and `owner` are `$clog2(N_REQ)` bits;
  - wrap from N_REQ-1 to 0 is explicit, with no reliance on power-of-two N_REQ.

## Timing
- Request accepted at edge T0. ISSUE runs in cycle T0+1, with `div_start` high in that cycle. WAIT covers DIV_LAT cycles.
- `resp_valid` is first high in cycle T0+DIV_LAT+2.
- If `resp_ready` is already high when `resp_valid` rises, the next grant is possible in cycle T0+DIV_LAT+3.
- Simultaneous requests: exactly one grant per IDLE cycle. A losing requester keeps `req_valid` high and is not dropped.
- Back-to-back streams from all requesters are served in strict rotation.

## Configuration
- `DIV_ARB_FASTPATH_EN`:
  - Defined: in IDLE, operands are classified at accept. Special cases go to RESP directly, `resp_valid` in T0+1, with no divider start and no WAIT:
    - either operand NaN, 0/0 or inf/inf → `64'h7FF8000000000000`;
    - x/0 with x finite non-zero, or inf/finite → ±inf, sign = XOR of operand signs, `7FF0…0`;
    - 0/x or finite/inf → ±0, sign = XOR of operand signs.
  - Undefined: every request, including specials, goes through the divider with full latency.

## Structure
- Package `div_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - constants `QNAN_D`, `INF_D` and `EXP_MAX_D=11'h7FF`;
  - special-operand classify functions (is_nan, is_inf, is_zero).
- One sub-module, `rr_pick`: combinational round-robin picker with inputs valid vector and `ptr`, and a one-hot grant output.

## Test plan
- Single op: requester 2 sends `4018000000000000`/`4000000000000000`, model divider returns `4008000000000000` → `div_start` at T0+1, `resp_valid[2]` at T0+DIV_LAT+2, `resp_z=4008000000000000`.
- All four valid continuously from reset → grant order 0,1,2,3,0; `ptr` wraps; exactly one `div_start` per op.
- After serving 1, requesters 0 and 3 are valid → 3 served before 0.
- `resp_ready` held low 5 cycles in RESP → `resp_z` stable, `req_ready` all 0, no `div_start`; release → IDLE next cycle.
- `3FF0000000000000`/`0` → with FASTPATH, `7FF0000000000000` at T0+1 and no `div_start`; without FASTPATH, `div_start` pulses and the result arrives at T0+DIV_LAT+2.
- `reset` low during WAIT → all outputs 0 immediately; after release, a new request is accepted with `ptr=0`.
